// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle control FSM and the datapath.
//   opcode    : instr[31:26] from the instruction register
//   mem_ready : memory access completes this cycle
//   pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca : datapath strobes
//   alusrcb   : 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   pcsrc     : 00 ALU result, 01 ALUOut, 10 jump target
//   aluop     : 00 add, 01 sub, 10 immediate class, 11 R-type
//   state     : current state code
//   illegal   : one-cycle pulse on an unsupported opcode
// master = control FSM, slave = datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite;
  logic       branch;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
    output alusrcb, pcsrc, aluop, state, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
    input  alusrcb, pcsrc, aluop, state, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : control bus (master side), see multicycle_control_if
// Outputs decode from the registered state; only irwrite/pcwrite in fetch also
// depend on mem_ready. While rst_n is low the strobes are forced off and the
// remaining controls show their fetch values.
module multicycle_control (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRtEx   = 4'd6,
    StAluWb  = 4'd7,
    StBeqEx  = 4'd8,
    StImmEx  = 4'd9,
    StImmWb  = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  state_e state_q, state_d;
  logic   bad_opcode;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // Next state; opcode is only looked at in decode and memadr.
  always_comb begin
    state_d    = StFetch;
    bad_opcode = 1'b0;
    case (state_q)
      StFetch:  state_d = bus.mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (bus.opcode)
          OpLw, OpSw:                    state_d = StMemAdr;
          OpRtype:                       state_d = StRtEx;
          OpBeq:                         state_d = StBeqEx;
          OpAddi, OpAndi, OpOri, OpSlti: state_d = StImmEx;
          OpJ:                           state_d = StJump;
          default: begin
            state_d    = StFetch;
            bad_opcode = 1'b1;
          end
        endcase
      end
      StMemAdr: state_d = (bus.opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = bus.mem_ready ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = bus.mem_ready ? StFetch : StMemWr;
      StRtEx:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBeqEx:  state_d = StFetch;
      StImmEx:  state_d = StImmWb;
      StImmWb:  state_d = StFetch;
      StJump:   state_d = StFetch;
      default:  state_d = StFetch; // unused codes 12-15 recover to fetch
    endcase
  end

  assign bus.state = state_q;

  always_comb begin
    bus.pcwrite  = 1'b0;
    bus.branch   = 1'b0;
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.aluop    = 2'b00;
    bus.illegal  = 1'b0;
    if (!rst_n) begin
      // Reset held: strobes off, everything else as in fetch.
      bus.alusrcb = 2'b01;
    end else begin
      case (state_q)
        StFetch: begin
          bus.alusrcb = 2'b01;
          bus.irwrite = bus.mem_ready;
          bus.pcwrite = bus.mem_ready;
        end
        StDecode: begin
          bus.alusrcb = 2'b11;
          bus.illegal = bad_opcode;
        end
        StMemAdr: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
        end
        StMemRd: bus.iord = 1'b1;
        StMemWb: begin
          bus.memtoreg = 1'b1;
          bus.regwrite = 1'b1;
        end
        StMemWr: begin
          bus.iord     = 1'b1;
          bus.memwrite = 1'b1;
        end
        StRtEx: begin
          bus.alusrca = 1'b1;
          bus.aluop   = 2'b11;
        end
        StAluWb: begin
          bus.regdst   = 1'b1;
          bus.regwrite = 1'b1;
        end
        StBeqEx: begin
          bus.alusrca = 1'b1;
          bus.aluop   = 2'b01;
          bus.pcsrc   = 2'b01;
          bus.branch  = 1'b1;
        end
        StImmEx: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
          bus.aluop   = 2'b10;
        end
        StImmWb: bus.regwrite = 1'b1;
        StJump: begin
          bus.pcsrc   = 2'b10;
          bus.pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Port list SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  instr[31:26], held stable by the external instruction register after the FETCH write
- mem_ready  in  1  memory access completes this cycle
- pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca  out  1 each  datapath controls
- alusrcb  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- aluop  out  2  00 add, 01 sub, 10 immediate class (downstream decodes opcode), 11 R-type (downstream decodes funct)
- state  out  4  current state code
- illegal  out  1  one-cycle pulse on an unsupported opcode

Function
REQ-003 The block SHALL be a Moore FSM with registered state; outputs are decoded from state, except irwrite/pcwrite in FETCH, which are gated by mem_ready.
REQ-004 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, ALUWB=7, BEQEX=8, IMMEX=9, IMMWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-005 Any output not listed for a state SHALL be 0.
REQ-006 FETCH: alusrcb=01, aluop=00, irwrite=pcwrite=mem_ready; stay while mem_ready=0; go to DECODE when mem_ready=1.
REQ-007 DECODE: alusrcb=11, aluop=00.
- Next state by opcode: 100011/101011 -> MEMADR; 000000 -> RTEX; 000100 -> BEQEX; 001000/001100/001101/001010 -> IMMEX; 000010 -> JUMP.
- Any other opcode -> FETCH with illegal=1 for that cycle only.
REQ-008 MEMADR: alusrca=1, alusrcb=10, aluop=00; opcode 100011 -> MEMRD, otherwise -> MEMWR.
REQ-009 MEMRD: iord=1; stay while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-010 MEMWB: memtoreg=1, regwrite=1, regdst=0; go to FETCH.
REQ-011 MEMWR: iord=1, memwrite=1; stay while mem_ready=0, with memwrite held; go to FETCH when mem_ready=1.
REQ-012 RTEX: alusrca=1, alusrcb=00, aluop=11; go to ALUWB.
REQ-013 ALUWB: regdst=1, regwrite=1; go to FETCH.
REQ-014 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; go to FETCH.
REQ-015 IMMEX: alusrca=1, alusrcb=10, aluop=10; go to IMMWB.
REQ-016 IMMWB: regwrite=1, regdst=0, memtoreg=0; go to FETCH.
REQ-017 JUMP: pcsrc=10, pcwrite=1; go to FETCH.
REQ-018 Each strobe SHALL be asserted for exactly the cycles listed above:
- regwrite: exactly one cycle per lw/R/imm instruction.
- pcwrite: exactly one cycle per instruction fetch and per jump.
REQ-019 Instruction latency, with mem_ready=1 throughout, SHALL be: lw 5, sw 4, R-type 4, imm 4, beq 3, j 3, illegal 2 cycles.
REQ-020 opcode SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.

Reset
REQ-021 When rst_n=0 at a rising edge, state SHALL become FETCH regardless of the current state, including mid-instruction and memory-wait states.
REQ-022 While rst_n=0, pcwrite, irwrite, regwrite, memwrite, branch and illegal SHALL be forced to 0 combinationally; all other outputs SHALL take their FETCH values.
REQ-023 After rst_n returns to 1, the first FETCH SHALL behave as REQ-006; no partially completed instruction SHALL resume.

Verification
REQ-024 lw (opcode 100011), mem_ready=1:
- state sequence 0,1,2,3,4,0.
- regwrite=1 and memtoreg=1 only in state 4.
REQ-025 R-type (opcode 000000): aluop=11 in state 6; regdst=1, regwrite=1 in state 7; total 4 cycles.
REQ-026 FETCH with mem_ready low for 3 cycles, then high:
- state stays 0 for 4 cycles.
- irwrite=pcwrite=1 only in the 4th cycle.
REQ-027 sw with mem_ready low for 2 cycles in MEMWR: memwrite=1 for 3 consecutive cycles, then state 0.
REQ-028 opcode 111111 in DECODE: illegal=1 for one cycle; next state 0; no regwrite/memwrite/pcwrite asserted.
REQ-029 rst_n=0 during MEMRD (state 3):
- next state 0, strobes 0 while reset is held.
- after release, a lw completes normally.
